alu_iter: RTL

Parametrised, registered successor to the single-cycle datapath ALU. It adds XOR, logical shifts and an iterative shift-add multiply, and uses a start/done handshake. The block sits in the execute stage of the multicycle processor. The controller issues one operation per `start` pulse and stalls on `busy` while a multiply iterates. Result and NZCV flags are registered and held until the next operation completes.

---
 rtl/alu_iter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_iter.sv
// alu_iter: registered execute-stage ALU with iterative shift-add multiply.
// Ports: clk, reset, start, ALUControl, A, B -> busy, done, Result, ALUFlags.
module alu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic [3:0]       ALUFlags
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_ORR = 3'b011;
   localparam logic [2:0] OP_EOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_LSL = 3'b110;
   localparam logic [2:0] OP_LSR = 3'b111;

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_t;

   state_t state, state_nxt;

   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shl;
   logic [WIDTH:0]   shr;
   logic [7:0]       amt;
   logic             amt_ok;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic [3:0]       alu_flags;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             accept;

   assign accept = start && (state == S_IDLE);

   // Single-cycle datapath for every op except MUL.
   always_comb begin
      sub    = (ALUControl == OP_SUB);
      b_eff  = sub ? ~B : B;
      sum    = {1'b0, A} + {1'b0, b_eff}
             + {{WIDTH{1'b0}}, sub};
      amt    = B[7:0];
      amt_ok = (32'(amt) < WIDTH);
      // Extra guard bit catches the last bit shifted out;
      // an amount of 0 leaves the guard bit at 0.
      shl    = {1'b0, A} << amt;
      shr    = {A, 1'b0} >> amt;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      unique case (ALUControl)
         OP_ADD, OP_SUB: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (A[WIDTH-1] == b_eff[WIDTH-1])
                   && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND: alu_res = A & B;
         OP_ORR: alu_res = A | B;
         OP_EOR: alu_res = A ^ B;
         OP_MUL: alu_res = '0;
         OP_LSL: begin
            if (amt_ok) begin
               alu_res = shl[WIDTH-1:0];
               alu_c   = shl[WIDTH];
            end
         end
         OP_LSR: begin
            if (amt_ok) begin
               alu_res = shr[WIDTH:1];
               alu_c   = shr[0];
            end
         end
      endcase
      alu_flags = {alu_res[WIDTH-1], ~|alu_res,
                   alu_c, alu_v};
   end

   // One shift-add step per cycle.
   always_comb begin
      acc_nxt = mplier[0] ? acc + mcand : acc;
      last    = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (accept && ALUControl == OP_MUL)
               state_nxt = S_MUL;
         end
         S_MUL: begin
            if (last) state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy = (state == S_MUL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         Result   <= '0;
         ALUFlags <= '0;
         done     <= 1'b0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  if (ALUControl == OP_MUL) begin
                     mcand  <= A;
                     mplier <= B;
                     acc    <= '0;
                     cnt    <= '0;
                  end else begin
                     Result   <= alu_res;
                     ALUFlags <= alu_flags;
                     done     <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  Result   <= acc_nxt;
                  ALUFlags <= {acc_nxt[WIDTH-1],
                               ~|acc_nxt, 2'b00};
                  done     <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
